// File: rtl/rv_plic_boot_pkg.sv
// Shared types, register map and helpers for the rv_plic boot arbiter.
package rv_plic_boot_pkg;

    typedef enum logic [2:0] {
        ST_PRIO   = 3'd0,
        ST_PRIO_W = 3'd1,
        ST_IE     = 3'd2,
        ST_IE_W   = 3'd3,
        ST_THR    = 3'd4,
        ST_THR_W  = 3'd5,
        ST_RUN    = 3'd6,
        ST_DRAIN  = 3'd7
    } boot_state_e;

    localparam int unsigned MAP_W = 32;

    localparam logic [MAP_W-1:0] PRIO_BASE    = 32'h0000_0000;
    localparam logic [MAP_W-1:0] IE0_BASE     = 32'h0000_2000;
    localparam logic [MAP_W-1:0] THRESH0_ADDR = 32'h0020_0000;

    // One boot write as issued by the sequencer (register-map width).
    typedef struct packed {
        logic [MAP_W-1:0] addr;
        logic [MAP_W-1:0] data;
    } boot_wr_t;

    // Enable bits for word w: bit i set when source 32*w+i exists.
    function automatic logic [MAP_W-1:0] ie_mask(input int unsigned w, input int unsigned n);
        logic [MAP_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAP_W; i++) begin
            if ((MAP_W * w + i) < n) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/rv_plic_boot_outstanding_tracker.sv
// Single-outstanding-transaction tracker that routes host responses to
// either the boot sequencer or the external request path.
module rv_plic_boot_outstanding_tracker #(
    parameter int unsigned data_width_p = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    grant_i,
    input  logic                    owner_ext_i,
    input  logic                    valid_i,
    input  logic [data_width_p-1:0] rdata_i,
    input  logic                    err_i,
    output logic                    outstanding_o,
    output logic                    boot_rsp_o,
    output logic                    boot_err_o,
    output logic                    ext_valid_o,
    output logic [data_width_p-1:0] ext_rdata_o,
    output logic                    ext_err_o
);

    logic out_q;
    logic ext_q;
    logic rsp;

    // Set on a grant (remembering who asked), cleared by the matching response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q <= 1'b0;
            ext_q <= 1'b0;
        end else if (grant_i) begin
            out_q <= 1'b1;
            ext_q <= owner_ext_i;
        end else if (valid_i && out_q) begin
            out_q <= 1'b0;
        end
    end

    // Responses with nothing in flight are dropped here.
    assign rsp           = valid_i & out_q;
    assign outstanding_o = out_q;
    assign boot_rsp_o    = rsp & ~ext_q;
    assign boot_err_o    = rsp & ~ext_q & err_i;
    assign ext_valid_o   = rsp & ext_q;
    assign ext_rdata_o   = (rsp & ext_q) ? rdata_i : '0;
    assign ext_err_o     = rsp & ext_q & err_i;

`ifndef SYNTHESIS
    unexpected_valid_a : assert property (@(posedge clk_i) disable iff (!rst_ni) valid_i |-> out_q)
        else $error("rv_plic_boot_outstanding_tracker: valid_i with no transaction in flight");
`endif

endmodule

// File: rtl/rv_plic_boot_arbiter.sv
// Shares the rv_plic host-adapter port between the boot sequencer that
// programs priorities/enables/threshold and the external request path.
module rv_plic_boot_arbiter
    import rv_plic_boot_pkg::*;
#(
    parameter int unsigned num_src_p     = 2,
    parameter int unsigned addr_width_p  = 32,
    parameter int unsigned data_width_p  = 32,
    parameter int unsigned init_prio_p   = 1,
    parameter int unsigned init_thresh_p = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      reinit_i,
    output logic                      done_o,
    output logic                      init_err_o,
    input  logic                      up_req_i,
    output logic                      up_gnt_o,
    input  logic [addr_width_p-1:0]   up_addr_i,
    input  logic                      up_we_i,
    input  logic [data_width_p-1:0]   up_wdata_i,
    input  logic [data_width_p/8-1:0] up_be_i,
    output logic                      up_valid_o,
    output logic [data_width_p-1:0]   up_rdata_o,
    output logic                      up_err_o,
    output logic                      req_o,
    input  logic                      gnt_i,
    output logic [addr_width_p-1:0]   addr_o,
    output logic                      we_o,
    output logic [data_width_p-1:0]   wdata_o,
    output logic [data_width_p/8-1:0] be_o,
    input  logic                      valid_i,
    input  logic [data_width_p-1:0]   rdata_i,
    input  logic                      err_i
);

    localparam int unsigned num_words_lp  = (num_src_p + 31) / 32;
    localparam int unsigned src_cnt_w_lp  = $clog2(num_src_p + 1);
    localparam int unsigned word_cnt_w_lp = $clog2(num_words_lp + 1);

    boot_state_e              state_q, state_d;
    logic [src_cnt_w_lp-1:0]  src_cnt_q, src_cnt_d, src_cnt_inc;
    logic [word_cnt_w_lp-1:0] word_cnt_q, word_cnt_d, word_cnt_inc;
    logic                     done_q, done_d;
    logic                     init_err_q, init_err_d;
    logic                     start_q;

    logic     boot_req;
    boot_wr_t boot_wr;
    logic     run_req;
    logic     grant;
    logic     owner_ext;
    logic     outstanding;
    logic     boot_rsp;
    logic     boot_err;

    assign src_cnt_inc  = src_cnt_q + src_cnt_w_lp'(1);
    assign word_cnt_inc = word_cnt_q + word_cnt_w_lp'(1);

    // State, counters and sticky flags; start_q holds off requests until the first cycle out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_PRIO;
            src_cnt_q  <= '0;
            word_cnt_q <= '0;
            done_q     <= 1'b0;
            init_err_q <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_cnt_q  <= src_cnt_d;
            word_cnt_q <= word_cnt_d;
            done_q     <= done_d;
            init_err_q <= init_err_d;
            start_q    <= 1'b1;
        end
    end

    // Boot sequence and passthrough next-state logic.
    always_comb begin
        state_d    = state_q;
        src_cnt_d  = src_cnt_q;
        word_cnt_d = word_cnt_q;
        done_d     = done_q;
        init_err_d = init_err_q;
        boot_req   = 1'b0;
        boot_wr    = '0;
        run_req    = 1'b0;

        case (state_q)
            ST_PRIO: begin
                boot_req     = start_q;
                boot_wr.addr = PRIO_BASE + (32'(src_cnt_q) << 2);
                boot_wr.data = 32'(init_prio_p);
                if (boot_req && gnt_i) state_d = ST_PRIO_W;
            end
            ST_PRIO_W: begin
                if (boot_rsp) begin
                    if (src_cnt_inc == src_cnt_w_lp'(num_src_p)) begin
                        src_cnt_d = '0;
                        state_d   = ST_IE;
                    end else begin
                        src_cnt_d = src_cnt_inc;
                        state_d   = ST_PRIO;
                    end
                end
            end
            ST_IE: begin
                boot_req     = start_q;
                boot_wr.addr = IE0_BASE + (32'(word_cnt_q) << 2);
                boot_wr.data = ie_mask(32'(word_cnt_q), num_src_p);
                if (boot_req && gnt_i) state_d = ST_IE_W;
            end
            ST_IE_W: begin
                if (boot_rsp) begin
                    if (word_cnt_inc == word_cnt_w_lp'(num_words_lp)) begin
                        word_cnt_d = '0;
                        state_d    = ST_THR;
                    end else begin
                        word_cnt_d = word_cnt_inc;
                        state_d    = ST_IE;
                    end
                end
            end
            ST_THR: begin
                boot_req     = start_q;
                boot_wr.addr = THRESH0_ADDR;
                boot_wr.data = 32'(init_thresh_p);
                if (boot_req && gnt_i) state_d = ST_THR_W;
            end
            ST_THR_W: begin
                if (boot_rsp) begin
                    done_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                run_req = up_req_i & ~outstanding;
                if (reinit_i) begin
                    done_d     = 1'b0;
                    init_err_d = 1'b0;
                    state_d    = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!outstanding) state_d = ST_PRIO;
            end
            default: state_d = ST_PRIO;
        endcase

        if (boot_err) init_err_d = 1'b1;
    end

    // Host-port mux: external fields in RUN, full-word boot writes otherwise.
    always_comb begin
        req_o   = 1'b0;
        addr_o  = '0;
        we_o    = 1'b0;
        wdata_o = '0;
        be_o    = '0;
        if (state_q == ST_RUN) begin
            req_o   = run_req;
            addr_o  = up_addr_i;
            we_o    = up_we_i;
            wdata_o = up_wdata_i;
            be_o    = up_be_i;
        end else if (boot_req) begin
            req_o   = 1'b1;
            addr_o  = addr_width_p'(boot_wr.addr);
            we_o    = 1'b1;
            wdata_o = data_width_p'(boot_wr.data);
            be_o    = '1;
        end
    end

    assign up_gnt_o   = run_req & gnt_i;
    assign grant      = req_o & gnt_i;
    assign owner_ext  = (state_q == ST_RUN);
    assign done_o     = done_q;
    assign init_err_o = init_err_q;

    rv_plic_boot_outstanding_tracker #(
        .data_width_p(data_width_p)
    ) u_tracker (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .grant_i       (grant),
        .owner_ext_i   (owner_ext),
        .valid_i       (valid_i),
        .rdata_i       (rdata_i),
        .err_i         (err_i),
        .outstanding_o (outstanding),
        .boot_rsp_o    (boot_rsp),
        .boot_err_o    (boot_err),
        .ext_valid_o   (up_valid_o),
        .ext_rdata_o   (up_rdata_o),
        .ext_err_o     (up_err_o)
    );

endmodule

// File: tb/tb_rv_plic_boot_arbiter.sv
// Directed bench for rv_plic_boot_arbiter with a behavioural boot/passthrough model.
module tb_rv_plic_boot_arbiter;

    localparam int unsigned NUM_SRC     = 2;
    localparam int unsigned INIT_PRIO   = 1;
    localparam int unsigned INIT_THRESH = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        reinit_i;
    logic        done_o;
    logic        init_err_o;
    logic        up_req_i;
    logic        up_gnt_o;
    logic [31:0] up_addr_i;
    logic        up_we_i;
    logic [31:0] up_wdata_i;
    logic [3:0]  up_be_i;
    logic        up_valid_o;
    logic [31:0] up_rdata_o;
    logic        up_err_o;
    logic        req_o;
    logic        gnt_i;
    logic [31:0] addr_o;
    logic        we_o;
    logic [31:0] wdata_o;
    logic [3:0]  be_o;
    logic        valid_i;
    logic [31:0] rdata_i;
    logic        err_i;

    rv_plic_boot_arbiter #(
        .num_src_p     (NUM_SRC),
        .addr_width_p  (32),
        .data_width_p  (32),
        .init_prio_p   (INIT_PRIO),
        .init_thresh_p (INIT_THRESH)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .reinit_i   (reinit_i),
        .done_o     (done_o),
        .init_err_o (init_err_o),
        .up_req_i   (up_req_i),
        .up_gnt_o   (up_gnt_o),
        .up_addr_i  (up_addr_i),
        .up_we_i    (up_we_i),
        .up_wdata_i (up_wdata_i),
        .up_be_i    (up_be_i),
        .up_valid_o (up_valid_o),
        .up_rdata_o (up_rdata_o),
        .up_err_o   (up_err_o),
        .req_o      (req_o),
        .gnt_i      (gnt_i),
        .addr_o     (addr_o),
        .we_o       (we_o),
        .wdata_o    (wdata_o),
        .be_o       (be_o),
        .valid_i    (valid_i),
        .rdata_i    (rdata_i),
        .err_i      (err_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Host adapter responder controls
    int          stall_cnt  = 0;
    logic [31:0] host_rdata = '0;
    logic        err_en     = 1'b0;
    logic [31:0] err_addr   = '0;

    // Observation logs
    logic [31:0] boot_a [$];
    logic [31:0] boot_d [$];
    int          boot_valid_cyc [$];
    int          done_rise_cyc [$];
    int          up_gnt_cyc [$];
    int          up_valid_cyc [$];
    logic [31:0] up_rdata_q [$];
    int          stall_seen = 0;

    task automatic clear_logs();
        boot_a.delete();
        boot_d.delete();
        boot_valid_cyc.delete();
        done_rise_cyc.delete();
        up_gnt_cyc.delete();
        up_valid_cyc.delete();
        up_rdata_q.delete();
        stall_seen = 0;
    endtask

    // Behavioural model state
    wr_t  exp_q [$];
    int   rsp_left;
    bit   m_done, m_err, m_drain, m_out, m_ext, m_started;

    function automatic void fill_boot();
        wr_t w;
        int  rem;
        exp_q.delete();
        for (int s = 0; s < int'(NUM_SRC); s++) begin
            w.a = 32'(4 * s);
            w.d = 32'(INIT_PRIO);
            exp_q.push_back(w);
        end
        for (int k = 0; k < int'((NUM_SRC + 31) / 32); k++) begin
            rem = int'(NUM_SRC) - 32 * k;
            w.a = 32'h2000 + 32'(4 * k);
            w.d = (rem >= 32) ? 32'hFFFF_FFFF : ((32'd1 << rem) - 32'd1);
            exp_q.push_back(w);
        end
        w.a = 32'h0020_0000;
        w.d = 32'(INIT_THRESH);
        exp_q.push_back(w);
        rsp_left = exp_q.size();
    endfunction

    function automatic void model_reset();
        fill_boot();
        m_done = 0; m_err = 0; m_drain = 0; m_out = 0; m_ext = 0; m_started = 0;
    endfunction

    // Host adapter: optional initial stall, grants on request, responds next cycle.
    initial begin
        logic        rsp_due;
        logic [31:0] rsp_data;
        logic        rsp_err;
        rsp_due = 0; rsp_data = '0; rsp_err = 0;
        gnt_i = 0; valid_i = 0; rdata_i = '0; err_i = 0;
        forever begin
            @(posedge clk_i);
            #2;
            gnt_i = 0; valid_i = 0; rdata_i = '0; err_i = 0;
            if (!rst_ni) begin
                rsp_due = 0;
            end else if (rsp_due) begin
                valid_i = 1; rdata_i = rsp_data; err_i = rsp_err; rsp_due = 0;
            end else if (req_o) begin
                if (stall_cnt > 0) begin
                    stall_cnt--;
                end else begin
                    gnt_i    = 1;
                    rsp_due  = 1;
                    rsp_err  = err_en && (addr_o == err_addr);
                    rsp_data = host_rdata;
                end
            end
        end
    end

    // Compare process: DUT outputs against the model every cycle.
    initial begin
        bit          run, booting, exp_req, rsp, m_out_cur, prev_pend, prev_done;
        logic [31:0] prev_addr, prev_wdata;
        model_reset();
        prev_pend = 0; prev_done = 0; prev_addr = '0; prev_wdata = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                chk("rst_ctrl", 64'({req_o, up_gnt_o, up_valid_o, done_o, init_err_o, we_o, be_o}), 64'(0));
                chk("rst_addr", 64'(addr_o), 64'(0));
                chk("rst_wdata", 64'(wdata_o), 64'(0));
                model_reset();
                prev_pend = 0;
                prev_done = 0;
                continue;
            end
            run     = m_done;
            booting = !m_done && !m_drain;
            if (run)          exp_req = up_req_i && !m_out;
            else if (m_drain) exp_req = 0;
            else              exp_req = m_started && !m_out;
            chk("req", 64'(req_o), 64'(exp_req));
            chk("up_gnt", 64'(up_gnt_o), 64'(run && exp_req && gnt_i));
            if (exp_req && run) begin
                chk("run_addr", 64'(addr_o), 64'(up_addr_i));
                chk("run_wdata", 64'(wdata_o), 64'(up_wdata_i));
                chk("run_ctl", 64'({we_o, be_o}), 64'({up_we_i, up_be_i}));
            end else if (exp_req && booting) begin
                chk("boot_pending", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    chk("boot_addr", 64'(addr_o), 64'(exp_q[0].a));
                    chk("boot_wdata", 64'(wdata_o), 64'(exp_q[0].d));
                    chk("boot_ctl", 64'({we_o, be_o}), 64'(5'h1F));
                end
            end
            if (prev_pend) begin
                chk("hold_req", 64'(req_o), 64'(1));
                chk("hold_addr", 64'(addr_o), 64'(prev_addr));
                chk("hold_wdata", 64'(wdata_o), 64'(prev_wdata));
            end
            rsp = valid_i && m_out;
            chk("up_valid", 64'(up_valid_o), 64'(rsp && m_ext));
            if (rsp && m_ext) begin
                chk("up_rdata", 64'(up_rdata_o), 64'(rdata_i));
                chk("up_err", 64'(up_err_o), 64'(err_i));
            end
            chk("done", 64'(done_o), 64'(m_done));
            chk("init_err", 64'(init_err_o), 64'(m_err));

            // observation logs
            if (booting && req_o && gnt_i) begin
                boot_a.push_back(addr_o);
                boot_d.push_back(wdata_o);
            end
            if (booting && req_o && !gnt_i) stall_seen++;
            if (rsp && !m_ext) boot_valid_cyc.push_back(cyc);
            if (done_o && !prev_done) done_rise_cyc.push_back(cyc);
            if (up_gnt_o) up_gnt_cyc.push_back(cyc);
            if (up_valid_o) begin
                up_valid_cyc.push_back(cyc);
                up_rdata_q.push_back(up_rdata_o);
            end
            prev_done = done_o;

            // advance the model to the next cycle
            m_out_cur = m_out;
            if (rsp) begin
                m_out = 0;
                if (!m_ext) begin
                    if (err_i) m_err = 1;
                    rsp_left--;
                    if (rsp_left == 0) m_done = 1;
                end
            end
            if (exp_req && gnt_i) begin
                m_out = 1;
                m_ext = run;
                if (!run && exp_q.size() > 0) exp_q.delete(0);
            end
            if (run && reinit_i) begin
                m_done  = 0;
                m_err   = 0;
                m_drain = 1;
                fill_boot();
            end else if (m_drain && !m_out_cur) begin
                m_drain = 0;
            end
            prev_pend  = booting && exp_req && !gnt_i;
            prev_addr  = addr_o;
            prev_wdata = wdata_o;
            m_started  = 1;
        end
    end

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!done_o && n < 300);
        #1;
        chk(name, 64'(done_o), 64'(1));
    endtask

    task automatic check_boot_log(input string name);
        logic [31:0] ea [4];
        logic [31:0] ed [4];
        ea = '{32'h0, 32'h4, 32'h2000, 32'h20_0000};
        ed = '{32'h1, 32'h1, 32'h3, 32'h0};
        chk({name, "_nwr"}, 64'(boot_a.size()), 64'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < boot_a.size()) begin
                chk({name, "_addr"}, 64'(boot_a[i]), 64'(ea[i]));
                chk({name, "_data"}, 64'(boot_d[i]), 64'(ed[i]));
            end
        end
    endtask

    // Directed stimulus
    initial begin
        bit found;
        rst_ni = 0; reinit_i = 0; up_req_i = 0; up_addr_i = '0;
        up_we_i = 0; up_wdata_i = '0; up_be_i = '0;
        repeat (3) @(posedge clk_i);

        // Boot from reset with an immediately granting host
        clear_logs();
        #1 rst_ni = 1;
        wait_done("t1_done");
        check_boot_log("t1");
        if (boot_valid_cyc.size() == 4 && done_rise_cyc.size() == 1)
            chk("t1_done_lat", 64'(done_rise_cyc[0] - boot_valid_cyc[3]), 64'(1));
        else
            chk("t1_events", 64'({boot_valid_cyc.size(), done_rise_cyc.size()}), {32'd4, 32'd1});
        chk("t1_no_upgnt", 64'(up_gnt_cyc.size()), 64'(0));
        chk("t1_no_stall", 64'(stall_seen), 64'(0));

        // Host stalls the first boot write for 5 cycles
        @(posedge clk_i);
        #1 rst_ni = 0;
        #1 chk("t2_async_done", 64'(done_o), 64'(0));
        stall_cnt = 5;
        repeat (2) @(posedge clk_i);
        clear_logs();
        #1 rst_ni = 1;
        wait_done("t2_done");
        chk("t2_stall", 64'(stall_seen), 64'(5));
        check_boot_log("t2");

        // External read of 0x200004 with back-to-back requests
        clear_logs();
        host_rdata = 32'h1;
        @(posedge clk_i);
        #1 up_req_i = 1; up_we_i = 0; up_addr_i = 32'h20_0004; up_be_i = 4'hF;
        repeat (3) @(posedge clk_i);
        #1 up_req_i = 0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("t3_ngnt", 64'(up_gnt_cyc.size()), 64'(2));
        chk("t3_nvalid", 64'(up_valid_cyc.size()), 64'(2));
        if (up_gnt_cyc.size() == 2 && up_valid_cyc.size() == 2) begin
            chk("t3_rsp_lat", 64'(up_valid_cyc[0] - up_gnt_cyc[0]), 64'(1));
            chk("t3_b2b_gap", 64'(up_gnt_cyc[1] - up_gnt_cyc[0]), 64'(2));
            chk("t3_rdata", 64'(up_rdata_q[0]), 64'(32'h1));
        end

        // reinit in the same cycle an external write is granted
        clear_logs();
        host_rdata = 32'hCAFE_0001;
        @(posedge clk_i);
        #1 up_req_i = 1; up_we_i = 1; up_addr_i = 32'h4; up_wdata_i = 32'h3; reinit_i = 1;
        @(posedge clk_i);
        #1 up_req_i = 0; reinit_i = 0;
        @(negedge clk_i);
        chk("t4_done_drop", 64'(done_o), 64'(0));
        wait_done("t4_done");
        chk("t4_ngnt", 64'(up_gnt_cyc.size()), 64'(1));
        chk("t4_nvalid", 64'(up_valid_cyc.size()), 64'(1));
        if (up_rdata_q.size() == 1) chk("t4_rdata", 64'(up_rdata_q[0]), 64'(32'hCAFE_0001));
        check_boot_log("t4");
        chk("t4_nrise", 64'(done_rise_cyc.size()), 64'(1));

        // err_i on the enable write
        clear_logs();
        err_en = 1; err_addr = 32'h2000;
        @(posedge clk_i);
        #1 reinit_i = 1;
        @(posedge clk_i);
        #1 reinit_i = 0;
        wait_done("t5_done");
        chk("t5_init_err", 64'(init_err_o), 64'(1));
        check_boot_log("t5");
        err_en = 0;

        // Reset while waiting for the enable-write response
        clear_logs();
        @(posedge clk_i);
        #1 reinit_i = 1;
        @(posedge clk_i);
        #1 reinit_i = 0;
        @(negedge clk_i);
        chk("t6_err_clr", 64'(init_err_o), 64'(0));
        found = 0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk_i);
            if (req_o && gnt_i && addr_o == 32'h2000) found = 1;
        end
        chk("t6_ie_grant", 64'(found), 64'(1));
        @(posedge clk_i);
        #1 rst_ni = 0;
        #1;
        chk("t6_req", 64'(req_o), 64'(0));
        chk("t6_done", 64'(done_o), 64'(0));
        repeat (2) @(posedge clk_i);
        clear_logs();
        #1 rst_ni = 1;
        wait_done("t6_done_again");
        check_boot_log("t6");

        repeat (2) @(posedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
